// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and period of an asynchronous PWM input in
// sys_clk cycles, and flags a static (non-toggling) input with its held level.
module pwm_duty_meter #(
  parameter int unsigned      CNT_W       = 20,
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(1_000_000)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic             static_level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             static_level_q, static_level_d;

  logic             rise;
  logic             fall;
  logic             per_expired;
  logic             idle_expired;

  // Synchroniser plus history flop; runs independently of en.
  always_comb begin
    s1_d = pwm_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise         = s2_q & ~s3_q;
  assign fall         = ~s2_q & s3_q;
  assign per_expired  = (per_q >= TIMEOUT_MAX);
  assign idle_expired = (idle_q >= TIMEOUT_MAX);

  always_comb begin
    state_d        = state_q;
    per_d          = per_q;
    hi_d           = hi_q;
    idle_d         = idle_q;
    high_cnt_d     = high_cnt_q;
    period_cnt_d   = period_cnt_q;
    meas_valid_d   = 1'b0;
    timeout_d      = timeout_q;
    static_level_d = static_level_q;

    if (!en) begin
      state_d   = IDLE;
      per_d     = CNT_ZERO;
      hi_d      = CNT_ZERO;
      idle_d    = CNT_ZERO;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          per_d = CNT_ZERO;
          hi_d  = CNT_ZERO;
          if (rise) begin
            // First edge only opens a measurement; nothing is published yet.
            state_d = HIGH;
            per_d   = CNT_ONE;
            hi_d    = CNT_ONE;
            idle_d  = CNT_ZERO;
          end else if (idle_expired) begin
            timeout_d      = 1'b1;
            static_level_d = s2_q;
            idle_d         = CNT_ZERO;
          end else begin
            idle_d = sat_inc(idle_q);
          end
        end

        HIGH: begin
          if (per_expired) begin
            state_d        = IDLE;
            per_d          = CNT_ZERO;
            hi_d           = CNT_ZERO;
            idle_d         = CNT_ZERO;
            timeout_d      = 1'b1;
            static_level_d = s2_q;
          end else begin
            per_d = sat_inc(per_q);
            if (fall) begin
              state_d = LOW;
            end else begin
              hi_d = sat_inc(hi_q);
            end
          end
        end

        LOW: begin
          // A rise coinciding with expiry still closes the period normally.
          if (rise) begin
            high_cnt_d   = hi_q;
            period_cnt_d = per_q;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            state_d      = HIGH;
            per_d        = CNT_ONE;
            hi_d         = CNT_ONE;
          end else if (per_expired) begin
            state_d        = IDLE;
            per_d          = CNT_ZERO;
            hi_d           = CNT_ZERO;
            idle_d         = CNT_ZERO;
            timeout_d      = 1'b1;
            static_level_d = s2_q;
          end else begin
            per_d = sat_inc(per_q);
          end
        end

        default: begin
          state_d = IDLE;
          per_d   = CNT_ZERO;
          hi_d    = CNT_ZERO;
          idle_d  = CNT_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      per_q          <= CNT_ZERO;
      hi_q           <= CNT_ZERO;
      idle_q         <= CNT_ZERO;
      high_cnt_q     <= CNT_ZERO;
      period_cnt_q   <= CNT_ZERO;
      meas_valid_q   <= 1'b0;
      timeout_q      <= 1'b0;
      static_level_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      per_q          <= per_d;
      hi_q           <= hi_d;
      idle_q         <= idle_d;
      high_cnt_q     <= high_cnt_d;
      period_cnt_q   <= period_cnt_d;
      meas_valid_q   <= meas_valid_d;
      timeout_q      <= timeout_d;
      static_level_q <= static_level_d;
    end
  end

  assign high_cnt     = high_cnt_q;
  assign period_cnt   = period_cnt_q;
  assign meas_valid   = meas_valid_q;
  assign timeout      = timeout_q;
  assign static_level = static_level_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: stimulus queues expected measurements,
// a monitor pops and compares them on every meas_valid pulse.
module tb_pwm_duty_meter;

  localparam int               CNT_W = 20;
  localparam logic [CNT_W-1:0] TMAX  = 20'd1000;
  // Rise driven after edge c: sampled at c+1, detected at c+3, expiry 1000 edges later.
  localparam int               TO_LAT = 1003;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             timeout;
  logic             static_level;

  pwm_duty_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_MAX (TMAX)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .en           (en),
    .pwm_in       (pwm_in),
    .high_cnt     (high_cnt),
    .period_cnt   (period_cnt),
    .meas_valid   (meas_valid),
    .timeout      (timeout),
    .static_level (static_level)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int h;
    int p;
    int gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   armed = 1'b0;
  bit   prev_pub = 1'b0;
  int   last_h = 0;
  int   last_p = 0;
  int   last_rise_cyc = 0;
  int   last_vld_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge sys_clk) begin : monitor
    exp_t e;
    if (meas_valid === 1'b1) begin
      check("valid_only_when_en", en, 1);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_meas_valid: got high=%0d period=%0d, expected no pulse (cycle %0d)",
                 high_cnt, period_cnt, cyc);
      end else begin
        e = sb_q.pop_front();
        check("high_cnt", high_cnt, e.h);
        check("period_cnt", period_cnt, e.p);
        if (e.gap != 0) check("valid_spacing", cyc - last_vld_cyc, e.gap);
      end
      last_vld_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic disarm();
    armed    = 1'b0;
    prev_pub = 1'b0;
  endtask

  // One PWM period starting with a rise; the rise closes the previous period.
  task automatic pwm_period(input int h, input int p);
    if (armed) begin
      sb_q.push_back(exp_t'{last_h, last_p, prev_pub ? last_p : 0});
      prev_pub = 1'b1;
    end
    armed         = 1'b1;
    last_rise_cyc = cyc;
    pwm_in        = 1'b1;
    step(h);
    pwm_in = 1'b0;
    step(p - h);
    last_h = h;
    last_p = p;
  endtask

  task automatic wait_timeout(input int max_cyc);
    int n = 0;
    while (timeout !== 1'b1 && n < max_cyc) begin
      step(1);
      n++;
    end
    check("timeout_seen", timeout, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_cnt"}, high_cnt, 0);
    check({tag, "_period_cnt"}, period_cnt, 0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_static_level"}, static_level, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_n = 1'b0;
    en        = 1'b0;
    pwm_in    = 1'b0;
    step(3);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    en        = 1'b1;
    step(2);

    // 30/100 stream, then duty change to 70/100 without a gap.
    repeat (5) pwm_period(30, 100);
    repeat (5) pwm_period(70, 100);

    // Input stuck low after the last rise.
    wait_timeout(1200);
    check("low_timeout_latency", cyc - last_rise_cyc, TO_LAT);
    check("low_static_level", static_level, 0);
    check("low_held_high_cnt", high_cnt, 70);
    check("low_held_period_cnt", period_cnt, 100);
    disarm();

    // en low clears timeout.
    en = 1'b0;
    step(2);
    check("en_low_clears_timeout", timeout, 0);
    en = 1'b1;
    step(2);

    // Input stuck high.
    armed         = 1'b1;
    last_rise_cyc = cyc;
    pwm_in        = 1'b1;
    wait_timeout(1200);
    check("high_timeout_latency", cyc - last_rise_cyc, TO_LAT);
    check("high_static_level", static_level, 1);
    check("high_held_high_cnt", high_cnt, 70);
    check("high_held_period_cnt", period_cnt, 100);
    disarm();
    pwm_in = 1'b0;
    step(50);
    pwm_period(40, 80);
    check("timeout_held_before_publish", timeout, 1);
    pwm_period(40, 80);
    check("timeout_cleared_by_publish", timeout, 0);
    pwm_period(40, 80);

    // Reset halfway through a 100-cycle period.
    repeat (3) pwm_period(30, 100);
    pwm_period(30, 50);
    sys_rst_n = 1'b0;
    disarm();
    step(2);
    check_all_zero("midreset");
    sys_rst_n = 1'b1;
    step(30);
    repeat (3) pwm_period(30, 100);

    // en dropped for 10 cycles mid-period.
    pwm_period(30, 50);
    en = 1'b0;
    disarm();
    step(5);
    check("en_low_meas_valid", meas_valid, 0);
    check("en_low_timeout", timeout, 0);
    step(5);
    en = 1'b1;
    step(40);
    repeat (4) pwm_period(30, 100);

    // Period exactly TIMEOUT_MAX: rise and expiry coincide, rise wins.
    repeat (2) pwm_period(500, 1000);
    pwm_period(30, 100);
    check("rise_beats_timeout", timeout, 0);

    step(10);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
